// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch response stage: FSM state encoding
// and the instruction word width.
package if_stage_pkg;

  localparam int unsigned INST_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_EXC  = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_stage_inst_buffer.sv
// One-entry holding register for an instruction word that ID could not take
// on the cycle it returned from the SRAM.
module if_stage_inst_buffer
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [INST_W-1:0] data_i,
  output logic              valid_o,
  output logic [INST_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [INST_W-1:0] data_q, data_d;

  // Clear has priority so a flush or hand-off can never leave a stale word behind.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch response stage: tracks the single outstanding SRAM request
// of the IF entry, buffers the word under ID back-pressure, forwards exceptions.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        pre_IF_IF_reg_valid,
  input  logic [31:0] curr_pc_IF,
  input  logic        exception_IF_in,
  input  logic [4:0]  exccode_IF_in,
  input  logic        tlb_refill_IF_in,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        discard_instruction,
  input  logic        flush,
  input  logic        IF_ID_reg_allow_in,
  output logic        pre_IF_IF_reg_stall_wait_for_data,
  output logic        IF_stall,
  output logic        IF_valid_out,
  output logic [31:0] inst_IF,
  output logic [31:0] pc_IF_out,
  output logic        exception_IF,
  output logic [4:0]  exccode_IF,
  output logic        tlb_refill_IF,
  output logic        leaving_IF
);

  if_state_e   state_q, state_d, cur_state;
  logic        resp_ok;
  logic        present_valid;
  logic [31:0] present_inst;
  logic        buf_load, buf_clear, buf_valid;
  logic [31:0] buf_data;

  assign resp_ok = inst_sram_data_ok & ~discard_instruction;

  // An entry waiting in IDLE is taken on in the same cycle, so a response that
  // arrives right after a hand-off is not lost and throughput stays at 1/cycle.
  always_comb begin
    cur_state = state_q;
    if (state_q == S_IDLE && pre_IF_IF_reg_valid) begin
      cur_state = exception_IF_in ? S_EXC : S_WAIT;
    end
  end

  always_comb begin
    state_d       = cur_state;
    present_valid = 1'b0;
    present_inst  = '0;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    case (cur_state)
      S_WAIT: begin
        if (resp_ok) begin
          present_valid = 1'b1;
          present_inst  = inst_sram_rdata;
          if (IF_ID_reg_allow_in) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_HOLD;
            buf_load = 1'b1;
          end
        end
      end
      S_HOLD: begin
        present_valid = buf_valid;
        present_inst  = buf_data;
        if (IF_ID_reg_allow_in) begin
          state_d   = S_IDLE;
          buf_clear = 1'b1;
        end
      end
      S_EXC: begin
        present_valid = 1'b1;
        if (IF_ID_reg_allow_in) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
    // A flush kills the entry outright, including a word returning this cycle.
    if (flush) begin
      state_d       = S_IDLE;
      present_valid = 1'b0;
      present_inst  = '0;
      buf_load      = 1'b0;
      buf_clear     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  if_stage_inst_buffer u_inst_buffer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (inst_sram_rdata),
    .valid_o (buf_valid),
    .data_o  (buf_data)
  );

  assign pre_IF_IF_reg_stall_wait_for_data = (cur_state == S_WAIT) & ~resp_ok;
  assign IF_stall      = pre_IF_IF_reg_stall_wait_for_data | (present_valid & ~IF_ID_reg_allow_in);
  assign IF_valid_out  = present_valid;
  assign inst_IF       = present_inst;
  assign pc_IF_out     = present_valid ? curr_pc_IF : 32'h0;
  assign exception_IF  = present_valid & (cur_state == S_EXC);
  assign exccode_IF    = exception_IF ? exccode_IF_in : 5'd0;
  assign tlb_refill_IF = exception_IF & tlb_refill_IF_in;
  assign leaving_IF    = present_valid & IF_ID_reg_allow_in;

endmodule
